vote_collector: RTL and testbench

Upstream front-end for the 5-input majority voter. It synchronises and debounces five raw "yes" push-buttons, and runs a timed voting session. Each button press during an open window is latched as a sticky vote. The latched 5-bit vector drives voter inputs A..E directly, and `done` marks when the result is final.

---
 rtl/vote_collector_pkg.sv | 9 +
 rtl/vote_collector_btn_debounce.sv | 33 +++
 rtl/vote_collector.sv | 63 ++++++
 tb/tb_vote_collector.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/vote_collector_pkg.sv
// vote_collector_pkg: shared FSM state encoding and voter count for the voting front-end.
package vote_collector_pkg;
    localparam int N_VOTERS = 5;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        CLOSED = 2'd2
    } state_t;
endpackage

// File: rtl/vote_collector_btn_debounce.sv
// btn_debounce: two-flop synchroniser, debounce counter and rising-edge press pulse for one button.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    logic       s0, s1, level;
    logic [7:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0    <= 1'b0;
            s1    <= 1'b0;
            level <= 1'b0;
            cnt   <= 8'd0;
            press <= 1'b0;
        end else begin
            s0    <= raw;
            s1    <= s0;
            press <= 1'b0;
            if (s1 == level)
                cnt <= 8'd0;
            else if (cnt == 8'(DB_CYCLES - 1)) begin
                level <= s1;
                cnt   <= 8'd0;
                press <= s1;
            end else
                cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/vote_collector.sv
// vote_collector: debounced button front-end and timed voting session feeding the majority voter.
module vote_collector
    import vote_collector_pkg::*;
#(
    parameter int DB_CYCLES     = 4,
    parameter int WINDOW_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] yes_btn,
    output logic [N_VOTERS-1:0] vote,
    output logic                busy,
    output logic                done,
    output logic [7:0]          remaining
);
    logic [N_VOTERS-1:0] press, merged;
    state_t              state;

    for (genvar i = 0; i < N_VOTERS; i++) begin : g_btn
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (yes_btn[i]),
            .press(press[i])
        );
    end

    assign merged = vote | press;

    // IDLE and CLOSED share the start behaviour; only OPEN accepts presses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vote      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= 8'd0;
        end else begin
            case (state)
                OPEN: begin
                    vote <= merged;
                    if (remaining == 8'd1 || &merged) begin
                        state     <= CLOSED;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        remaining <= 8'd0;
                    end else
                        remaining <= remaining - 8'd1;
                end
                default: begin
                    if (start) begin
                        state     <= OPEN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        vote      <= '0;
                        remaining <= 8'(WINDOW_CYCLES);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vote_collector.sv
// tb_vote_collector: directed and random checks of vote_collector against a sample-window reference model.
module tb_vote_collector;
    localparam int DB = 4;
    localparam int W  = 16;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [4:0] yes_btn, vote;
    logic       busy, done;
    logic [7:0] remaining;

    vote_collector #(.DB_CYCLES(DB), .WINDOW_CYCLES(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .yes_btn  (yes_btn),
        .vote     (vote),
        .busy     (busy),
        .done     (done),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    // model: raw history (newest first), accepted levels, press pulses, session state
    logic [4:0] hist[$];
    logic [4:0] m_level, m_press, m_vote;
    int         m_state, m_rem;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < DB + 2; k++) hist.push_front(5'd0);
        m_level = 0; m_press = 0; m_vote = 0; m_state = 0; m_rem = 0;
    endtask

    task automatic tick();
        logic [4:0] acc, nv;
        // a level flips when the last DB synchronised samples all disagree with it
        for (int i = 0; i < 5; i++) begin
            acc[i] = 1'b1;
            for (int k = 1; k <= DB; k++) if (hist[k][i] == m_level[i]) acc[i] = 1'b0;
        end
        if (m_state == 1) begin
            nv = m_vote | m_press;
            m_vote = nv;
            if (m_rem == 1 || nv == 5'b11111) begin m_state = 2; m_rem = 0; end
            else m_rem = m_rem - 1;
        end else if (start) begin
            m_state = 1; m_vote = 0; m_rem = W;
        end
        m_press = acc & ~m_level;
        m_level = m_level ^ acc;
        hist.push_front(yes_btn);
        void'(hist.pop_back());
        @(posedge clk);
        #1;
        chk("vote", vote, m_vote);
        chk("busy", busy, m_state == 1);
        chk("done", done, m_state == 2);
        chk("remaining", remaining, m_rem);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_vote", vote, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rem", remaining, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; yes_btn = 5'd0;
        #2;
        do_reset();
        ticks(2);

        // basic session: presses on bits 4, 2, 0
        pulse_start();
        chk("open_busy", busy, 1);
        chk("open_rem", remaining, W);
        yes_btn[4] = 1'b1; ticks(3);
        yes_btn[2] = 1'b1; ticks(3);
        yes_btn[0] = 1'b1; ticks(9);
        chk("last_open_busy", busy, 1);
        tick();
        chk("basic_vote", vote, 5'b10101);
        chk("basic_done", done, 1);
        chk("basic_rem", remaining, 0);
        chk("majority", ($countones(vote) >= 3), 1);
        yes_btn = 0; ticks(8);

        // reset mid-session
        pulse_start();
        yes_btn = 5'b10100; ticks(8);
        chk("pre_rst_vote", vote, 5'b10100);
        yes_btn = 0;
        do_reset();
        ticks(3);

        // bounce on bit 3, glitch on bit 1, window opened mid-bounce
        for (int c = 0; c < 20; c++) begin
            yes_btn[3] = ((c / 2) % 2 == 0);
            yes_btn[1] = (c >= 2 && c <= 4);
            start = (c == 14);
            tick();
        end
        start = 1'b0;
        yes_btn[3] = 1'b1;
        ticks(6);
        chk("bounce_early", vote[3], 0);
        tick();
        chk("bounce_vote3", vote[3], 1);
        chk("glitch_vote1", vote[1], 0);
        ticks(5);
        yes_btn = 0; ticks(8);

        // pre-held button needs a fresh edge
        yes_btn[1] = 1'b1; ticks(10);
        pulse_start();
        ticks(2);
        chk("preheld", vote[1], 0);
        yes_btn[1] = 1'b0; ticks(6);
        yes_btn[1] = 1'b1; ticks(7);
        chk("repress", vote[1], 1);
        ticks(3);
        yes_btn = 0; ticks(8);

        // early close once all five votes are in
        pulse_start();
        for (int i = 0; i < 5; i++) begin yes_btn[i] = 1'b1; tick(); end
        ticks(6);
        chk("early_vote", vote, 5'b11111);
        chk("early_done", done, 1);
        chk("early_rem", remaining, 0);
        yes_btn = 0; ticks(8);

        // ignored start in OPEN, ignored press in CLOSED, restart from CLOSED
        pulse_start();
        yes_btn[0] = 1'b1; ticks(3);
        pulse_start();
        chk("no_reload", remaining, W - 4);
        ticks(12);
        chk("ign_done", done, 1);
        yes_btn = 5'b01000; ticks(8);
        chk("closed_press", vote, 5'b00001);
        yes_btn = 0; ticks(8);
        pulse_start();
        chk("restart_vote", vote, 0);
        chk("restart_rem", remaining, W);
        chk("restart_busy", busy, 1);
        ticks(18);

        // random stimulus with stable-run buttons and sporadic starts
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) yes_btn = 5'($urandom);
            start = ($urandom_range(0, 24) == 0);
            tick();
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
